// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and register-index constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MC_BUSY  = 2'd2,
    HALT     = 2'd3
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a decode-stage read of the register an in-flight EX load is about to write.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd_idx,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic                 rs1_used,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic                 rs2_used,
  output logic                 hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_used && (rs1_idx == ex_rd_idx);
  assign rs2_hit = rs2_used && (rs2_idx == ex_rd_idx);

  // x0 is hardwired to zero, so a load targeting it never produces a real dependency
  assign hazard = ex_valid && ex_is_load && (ex_rd_idx != REG_X0) && id_valid
                  && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the PC, F/D, D/E and E/M registers of the 4-stage core.
// Optional stall-cycle counter enabled with `define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_id_valid,
  input  logic [REG_IDX_W-1:0] i_id_rs1_idx,
  input  logic [REG_IDX_W-1:0] i_id_rs2_idx,
  input  logic                 i_id_rs1_used,
  input  logic                 i_id_rs2_used,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_is_load,
  input  logic [REG_IDX_W-1:0] i_ex_rd_idx,
  input  logic                 i_ex_is_mc,
  input  logic                 i_ex_is_eof,
  input  logic                 i_ex_branch_taken,
  input  logic                 i_mem_req,
  input  logic                 i_mem_ack,
  output logic                 o_pc_en,
  output logic                 o_fd_en,
  output logic                 o_de_en,
  output logic                 o_em_en,
  output logic                 o_de_bubble,
  output logic                 o_fd_flush,
  output logic                 o_halt,
  output logic [1:0]           o_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]          o_stall_cnt
`endif
);

  // mc_cnt is 2 bits wide, so MC_LAT must stay within 2..5
  localparam logic [1:0] MC_INIT = 2'(MC_LAT - 2);

  state_t     state, state_nx;
  logic [1:0] mc_cnt, mc_cnt_nx;
  logic       load_use;
  logic       pc_en, fd_en, de_en, em_en, de_bubble, fd_flush, halt;

  load_use_detect u_load_use (
    .ex_valid   (i_ex_valid),
    .ex_is_load (i_ex_is_load),
    .ex_rd_idx  (i_ex_rd_idx),
    .id_valid   (i_id_valid),
    .rs1_idx    (i_id_rs1_idx),
    .rs1_used   (i_id_rs1_used),
    .rs2_idx    (i_id_rs2_idx),
    .rs2_used   (i_id_rs2_used),
    .hazard     (load_use)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= RUN;
      mc_cnt <= 2'd0;
    end else begin
      state  <= state_nx;
      mc_cnt <= mc_cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mc_cnt_nx = mc_cnt;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    de_bubble = 1'b0;
    fd_flush  = 1'b0;
    halt      = 1'b0;
    case (state)
      RUN: begin
        if (i_mem_req && !i_mem_ack) begin
          {pc_en, fd_en, de_en, em_en} = 4'b0000;
          state_nx = MEM_WAIT;
        end else if (i_ex_valid && i_ex_is_mc) begin
          {pc_en, fd_en, de_en, em_en} = 4'b0000;
          mc_cnt_nx = MC_INIT;
          state_nx  = MC_BUSY;
        end else if (i_ex_valid && i_ex_is_eof) begin
          {pc_en, fd_en, de_en, em_en} = 4'b0000;
          state_nx = HALT;
        end else if (i_ex_valid && i_ex_branch_taken) begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
        end else if (load_use) begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_bubble = 1'b1;
        end
      end
      // the ack cycle releases the pipe without evaluating any RUN hazard
      MEM_WAIT: begin
        if (i_mem_ack) begin
          state_nx = RUN;
        end else begin
          {pc_en, fd_en, de_en, em_en} = 4'b0000;
        end
      end
      MC_BUSY: begin
        if (mc_cnt != 2'd0) begin
          {pc_en, fd_en, de_en, em_en} = 4'b0000;
          mc_cnt_nx = mc_cnt - 2'd1;
        end else begin
          state_nx = RUN;
        end
      end
      HALT: begin
        {pc_en, fd_en, de_en, em_en} = 4'b0000;
        halt = 1'b1;
      end
      default: state_nx = RUN;
    endcase
  end

  assign o_pc_en     = pc_en     && !i_rst;
  assign o_fd_en     = fd_en     && !i_rst;
  assign o_de_en     = de_en     && !i_rst;
  assign o_em_en     = em_en     && !i_rst;
  assign o_de_bubble = de_bubble && !i_rst;
  assign o_fd_flush  = fd_flush  && !i_rst;
  assign o_halt      = halt      && !i_rst;
  assign o_state     = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= 32'd0;
    end else if (!pc_en && (state != HALT) && (o_stall_cnt != 32'hFFFF_FFFF)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: per-cycle expected outputs are queued at drive time.
module tb_pipe_hazard_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_id_valid;
  logic [4:0] i_id_rs1_idx, i_id_rs2_idx;
  logic       i_id_rs1_used, i_id_rs2_used;
  logic       i_ex_valid, i_ex_is_load;
  logic [4:0] i_ex_rd_idx;
  logic       i_ex_is_mc, i_ex_is_eof, i_ex_branch_taken;
  logic       i_mem_req, i_mem_ack;
  logic       o_pc_en, o_fd_en, o_de_en, o_em_en;
  logic       o_de_bubble, o_fd_flush, o_halt;
  logic [1:0] o_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] o_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  pipe_hazard_ctrl #(.MC_LAT(4)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_id_valid        (i_id_valid),
    .i_id_rs1_idx      (i_id_rs1_idx),
    .i_id_rs2_idx      (i_id_rs2_idx),
    .i_id_rs1_used     (i_id_rs1_used),
    .i_id_rs2_used     (i_id_rs2_used),
    .i_ex_valid        (i_ex_valid),
    .i_ex_is_load      (i_ex_is_load),
    .i_ex_rd_idx       (i_ex_rd_idx),
    .i_ex_is_mc        (i_ex_is_mc),
    .i_ex_is_eof       (i_ex_is_eof),
    .i_ex_branch_taken (i_ex_branch_taken),
    .i_mem_req         (i_mem_req),
    .i_mem_ack         (i_mem_ack),
    .o_pc_en           (o_pc_en),
    .o_fd_en           (o_fd_en),
    .o_de_en           (o_de_en),
    .o_em_en           (o_em_en),
    .o_de_bubble       (o_de_bubble),
    .o_fd_flush        (o_fd_flush),
    .o_halt            (o_halt),
    .o_state           (o_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .o_stall_cnt       (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // expected vector layout: {pc_en, fd_en, de_en, em_en, bubble, flush, halt, state[1:0]}
  function automatic logic [8:0] mk(input logic [3:0] en, input logic bub, input logic fl,
                                    input logic hlt, input logic [1:0] st);
    return {en, bub, fl, hlt, st};
  endfunction

  localparam logic [8:0] E_RUN = {4'b1111, 3'b000, 2'd0};

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {23'd0, o_pc_en, o_fd_en, o_de_en, o_em_en, o_de_bubble, o_fd_flush, o_halt, o_state},
            {23'd0, e});
    end
  end

  task automatic clr_in();
    i_id_valid = 0; i_id_rs1_idx = 0; i_id_rs2_idx = 0;
    i_id_rs1_used = 0; i_id_rs2_used = 0;
    i_ex_valid = 0; i_ex_is_load = 0; i_ex_rd_idx = 0;
    i_ex_is_mc = 0; i_ex_is_eof = 0; i_ex_branch_taken = 0;
    i_mem_req = 0; i_mem_ack = 0;
  endtask

  // inputs are already applied; queue the expectation and advance one cycle
  task automatic cyc(input string tag, input logic [8:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd_idx = rd;
    i_id_valid = 1; i_id_rs1_idx = rs1; i_id_rs1_used = u1;
    i_id_rs2_idx = rs2; i_id_rs2_used = u2;
  endtask

  initial begin
    clr_in();
    i_rst = 1;
    @(posedge i_clk); #1;
    cyc("rst_hold", mk(4'b0000, 0, 0, 0, 2'd0));
    i_rst = 0;
    cyc("idle", E_RUN);

    set_load_use(5'd5, 5'd5, 1, 5'd0, 0);
    cyc("lu_rs1_stall", mk(4'b0011, 1, 0, 0, 2'd0));
    clr_in();
    cyc("lu_rs1_after", E_RUN);
    set_load_use(5'd7, 5'd1, 1, 5'd7, 1);
    cyc("lu_rs2_stall", mk(4'b0011, 1, 0, 0, 2'd0));
    set_load_use(5'd7, 5'd1, 1, 5'd7, 0);
    cyc("lu_rs2_unused", E_RUN);
    set_load_use(5'd0, 5'd0, 1, 5'd0, 1);
    cyc("lu_x0", E_RUN);
    set_load_use(5'd9, 5'd9, 1, 5'd0, 0);
    i_id_valid = 0;
    cyc("lu_id_invalid", E_RUN);
    clr_in();

    i_ex_valid = 1; i_ex_is_mc = 1;
    cyc("mc_c1", mk(4'b0000, 0, 0, 0, 2'd0));
    i_mem_req = 1;
    cyc("mc_c2", mk(4'b0000, 0, 0, 0, 2'd2));
    cyc("mc_c3", mk(4'b0000, 0, 0, 0, 2'd2));
    cyc("mc_c4", mk(4'b1111, 0, 0, 0, 2'd2));
    clr_in();
    cyc("mc_after", E_RUN);

    set_load_use(5'd3, 5'd3, 1, 5'd0, 0);
    i_ex_branch_taken = 1;
    cyc("br_lu", mk(4'b1111, 1, 1, 0, 2'd0));
    clr_in();

    i_ex_valid = 1; i_ex_branch_taken = 1; i_mem_req = 1;
    cyc("mem_t0", mk(4'b0000, 0, 0, 0, 2'd0));
    cyc("mem_t1", mk(4'b0000, 0, 0, 0, 2'd1));
    cyc("mem_t2", mk(4'b0000, 0, 0, 0, 2'd1));
    i_mem_ack = 1;
    cyc("mem_t3_ack", mk(4'b1111, 0, 0, 0, 2'd1));
    i_mem_req = 0; i_mem_ack = 0;
    cyc("mem_br_retry", mk(4'b1111, 1, 1, 0, 2'd0));
    clr_in();
    i_mem_req = 1; i_mem_ack = 1;
    cyc("mem_same_cycle", E_RUN);
    clr_in();
    cyc("mem_same_after", E_RUN);

    i_ex_valid = 1; i_ex_is_eof = 1;
    cyc("eof", mk(4'b0000, 0, 0, 0, 2'd0));
    clr_in();
    i_mem_req = 1;
    for (int k = 0; k < 10; k++) cyc($sformatf("halt_%0d", k), mk(4'b0000, 0, 0, 1, 2'd3));
    clr_in();
    i_rst = 1;
    cyc("halt_rst_gate", mk(4'b0000, 0, 0, 0, 2'd3));
    cyc("halt_rst_state", mk(4'b0000, 0, 0, 0, 2'd0));
    i_rst = 0;
    cyc("halt_rst_rel", E_RUN);

    i_ex_valid = 1; i_ex_is_mc = 1;
    cyc("mcr_c1", mk(4'b0000, 0, 0, 0, 2'd0));
    cyc("mcr_c2", mk(4'b0000, 0, 0, 0, 2'd2));
    i_rst = 1;
    cyc("mcr_rst_gate", mk(4'b0000, 0, 0, 0, 2'd2));
    clr_in();
    cyc("mcr_rst_state", mk(4'b0000, 0, 0, 0, 2'd0));
    i_rst = 0;
    cyc("mcr_rel", E_RUN);
    cyc("mcr_rel2", E_RUN);

    @(posedge i_clk); #1;
    check("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
